// File: rtl/mel_energy_accum.sv
// mel_energy_accum: triangular mel-weighted band energy accumulation with per-band handoff to the log stage
module mel_energy_accum #(
    parameter int NUM_BINS  = 256,
    parameter int NUM_BANDS = 26,
    parameter int PWR_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic [PWR_W-1:0] pwr_in,
    input  logic             pwr_valid,
    output logic             pwr_ready,
    output logic [7:0]       coef_addr,
    input  logic [21:0]      coef_data,
    output logic             log_start,
    output logic [63:0]      log_data,
    input  logic             log_dv,
    output logic [5:0]       band_idx,
    output logic             frame_done
);
    localparam int PRW = PWR_W + 16;
    localparam int AW  = $clog2(NUM_BANDS);

    typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, EMIT, WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [7:0]       bin_cnt;
    logic [1:0]       flush_cnt;
    logic [5:0]       band_nxt;
    logic [63:0]      acc [NUM_BANDS];
    logic             v1, v2;
    logic [PWR_W-1:0] pwr1;
    logic [PRW-1:0]   pu2, pl2;
    logic [5:0]       band2;
    logic [16:0]      wc;
    logic             accept;
    logic             clear;

    assign accept    = pwr_valid & pwr_ready;
    assign clear     = (state == IDLE) & frame_start;
    assign coef_addr = bin_cnt;
    assign wc        = 17'h10000 - {1'b0, coef_data[15:0]};
    assign band_nxt  = (state == FLUSH) ? 6'd0 : band_idx + 6'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = frame_start ? ACCUM : IDLE;
            ACCUM:   state_nxt = (accept && bin_cnt == 8'(NUM_BINS - 1)) ? FLUSH : ACCUM;
            FLUSH:   state_nxt = (flush_cnt == 2'd2) ? EMIT : FLUSH;
            EMIT:    state_nxt = WAIT;
            WAIT:    state_nxt = !log_dv ? WAIT : (band_idx == 6'(NUM_BANDS - 1)) ? DONE : EMIT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pwr_ready  = (state == ACCUM);
        log_start  = (state == EMIT);
        frame_done = (state == DONE);
    end

    // Three-stage pipeline: S1 captures the sample while the ROM reads, S2 splits it across the band pair, S3 accumulates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_cnt   <= '0;
            flush_cnt <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            pwr1      <= '0;
            pu2       <= '0;
            pl2       <= '0;
            band2     <= '0;
            band_idx  <= '0;
            log_data  <= '0;
            for (int b = 0; b < NUM_BANDS; b++)
                acc[b] <= '0;
        end else begin
            v1 <= accept;
            if (accept)
                pwr1 <= pwr_in;
            v2 <= v1;
            if (v1) begin
                pu2   <= PRW'(pwr1) * PRW'(coef_data[15:0]);
                pl2   <= PRW'(pwr1) * PRW'(wc);
                band2 <= coef_data[21:16];
            end
            bin_cnt   <= clear ? 8'd0 : accept ? bin_cnt + 8'd1 : bin_cnt;
            flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
            if (state_nxt == EMIT) begin
                band_idx <= band_nxt;
                log_data <= acc[band_nxt[AW-1:0]];
            end
            // Band 63 and anything above NUM_BANDS match no index here, so they drop out naturally
            for (int b = 0; b < NUM_BANDS; b++)
                if (clear)
                    acc[b] <= '0;
                else if (v2)
                    acc[b] <= acc[b] + ((band2 == 6'(b)) ? 64'(pu2) : 64'd0)
                                     + ((band2 == 6'(b + 1)) ? 64'(pl2) : 64'd0);
        end
    end
endmodule
